// File: rtl/seq101_stream_tx.sv
// seq101_stream_tx: MSB-first serializer feeding a "101" Mealy detector, with a golden detector copy
// Ports:
//   clk, aresetn        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   word handshake, in_data (W bits) sampled on transfer
//   x, x_valid, busy    registered serial bit, data-bit flag, word-in-flight flag
//   z_exp, det_count    expected Mealy detector output for current x, saturating pulse count
// Optional: define SEQ101_TX_PARITY_EN to append an even-parity bit after every word.
module seq101_stream_tx #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          x,
  output logic          x_valid,
  output logic          busy,
  output logic          z_exp,
  output logic [CW-1:0] det_count
);
`ifdef SEQ101_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int BW = $clog2(NB);
  typedef enum logic [1:0] {S0, S1, S10} st_t;
  logic          x_q, x_d, xv_q, xv_d, busy_q, busy_d, last, xfer;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [NB-1:0] sh_q, sh_d, frame;
  logic [CW-1:0] det_q, det_d;
  st_t           st_q, st_d;
`ifdef SEQ101_TX_PARITY_EN
  assign frame = {in_data, ^in_data};
`else
  assign frame = in_data;
`endif
  // last bit of the frame is on x: a new word may be accepted now for a gapless stream
  assign last     = busy_q && (cnt_q == BW'(NB - 1));
  assign in_ready = aresetn & (!busy_q | last);
  assign xfer     = in_valid & in_ready;
  assign x        = x_q;
  assign x_valid  = xv_q;
  assign busy     = busy_q;
  assign z_exp    = (st_q == S10) & x_q;
  assign det_count = det_q;
  always_comb begin
    x_d    = xfer ? frame[NB-1] : (busy_q && !last) ? sh_q[NB-1] : 1'b0;
    xv_d   = xfer | (busy_q & !last);
    busy_d = xfer | (busy_q & !last);
    cnt_d  = (busy_q && !last && !xfer) ? cnt_q + 1'b1 : '0;
    // shift register holds the bits still to be sent, next one at the MSB
    sh_d   = xfer ? frame << 1 : sh_q << 1;
    st_d   = x_q ? S1 : (st_q == S1) ? S10 : S0;
    det_d  = (z_exp && det_q != '1) ? det_q + 1'b1 : det_q;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_q    <= 1'b0;
      xv_q   <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      st_q   <= S0;
      det_q  <= '0;
    end else begin
      x_q    <= x_d;
      xv_q   <= xv_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      st_q   <= st_d;
      det_q  <= det_d;
    end
  end
endmodule

// File: doc/seq101_stream_tx.md
Name: seq101_stream_tx

Overview:
- Serial transmitter feeding the "101" Mealy sequence-detector interface (single-bit x, detector output z).
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first on x, one bit per clock.
- Idle cycles drive x=0.
- Carries an internal golden copy of the overlapping "101" Mealy detector, tracking the emitted stream. It drives z_exp and a detection count so a bench can compare against any detector wired to x.

Parameters:
- W, 8, data word width in bits (>=2).
- CW, 8, width of the saturating detection counter.

Ports:
- clk  input  1  rising-edge clock
- aresetn  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  W  word to serialize, MSB sent first
- x  output  1  serial bit stream (registered); 0 when idle
- x_valid  output  1  x carries a data bit (0 on idle fill)
- busy  output  1  a word is being shifted
- z_exp  output  1  expected detector output for the current x
- det_count  output  CW  number of z_exp pulses since reset, saturating

Behaviour:
- Reset (aresetn low, asynchronous, takes effect immediately):
  - x=0, x_valid=0, busy=0, z_exp=0, det_count=0.
  - Bit counter=0, tracker state=S0, shift register cleared.
  - in_ready=1 while aresetn is high and idle.
- Reset asserted mid-word: the word is discarded. After release the block is idle and the stream restarts from x=0.
- Handshake:
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - in_ready = !busy | (busy & bit counter == W-1), which allows back-to-back words with no gap bit.
  - in_data is sampled only on a transfer.
  - in_valid without in_ready has no effect; no internal queue.
- Latency: after a transfer at edge k, x = in_data[W-1] and x_valid=1 from edge k until edge k+1. Bit i (MSB=0) appears in cycle k+i.
- Shifting:
  - busy=1 for exactly W cycles per word.
  - At the last bit, with no new transfer, the next cycle is idle: x=0, x_valid=0, busy=0.
  - With a transfer at the last bit, the next word's MSB follows immediately.
- Tracker FSM: advances every clock on the current registered x, including idle zeros.
  - S0: x=1 -> S1; x=0 -> S0.
  - S1: x=1 -> S1; x=0 -> S10.
  - S10: x=1 -> S1 with z; x=0 -> S0.
  - Overlap allowed: 10101 gives two detections.
- z_exp = (state==S10) & x. It is combinational from registered state and x, valid in the same cycle as the completing bit (Mealy timing).
- det_count: increments on each edge where z_exp=1 and saturates at 2^CW-1 (no wrap).
- Tracker state persists across words and idle gaps. Only reset clears it.

Optional Feature:
- Macro: SEQ101_TX_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit (XOR of the W data bits), sent with x_valid=1.
  - busy lasts W+1 cycles.
  - in_ready early-accept moves to the parity-bit cycle.
  - The parity bit feeds the tracker like any other bit.
- Undefined: W bits per word, no parity bit, behaviour as above.

Test Plan:
- Reset release, no in_valid for 5 cycles -> x=0, x_valid=0, busy=0, in_ready=1, z_exp=0, det_count=0 throughout.
- Single word 8'hA8 (10101000) -> x=1,0,1,0,1,0,0,0 over 8 cycles. z_exp=1 only on bits 2 and 4; det_count=2; busy drops the cycle after bit 7.
- Back-to-back 8'h05 then 8'hA0, in_valid held high -> 16 contiguous bits, no idle gap. z_exp on stream bits 7 and 10; det_count=2.
- Cross-word detection: 8'h02 then 8'h80 back-to-back -> z_exp on the first bit of the second word (det_count=1). Repeating with a 1-cycle in_valid gap -> idle 0 breaks the sequence; det_count stays 0.
- aresetn pulsed low at bit 3 of 8'hFF -> x=0, x_valid=0, busy=0, det_count=0 immediately, without waiting for a clock edge. After release, a new word 8'h05 -> z_exp on its bit 7.
- Saturation with CW=2: stream 8'hAA twice back-to-back -> det_count reaches 3 and holds. With SEQ101_TX_PARITY_EN and 8'h01 -> 9 bits 000000011; parity bit=1; busy lasts 9 cycles.
